// File: rtl/pc_fetch_unit_pkg.sv
// Shared constants and sizing helper for the fetch unit and its instruction buffer.
package fetch_defs;
  localparam int          PC_STEP       = 4;
  localparam int          INSTR_W       = 32;
  localparam logic [31:0] DEF_RESET_VEC = 32'h0000_0000;

  // Counter width able to hold the values 0..depth inclusive.
  function automatic int cnt_w(input int depth);
    return $clog2(depth) + 1;
  endfunction
endpackage

// File: rtl/pc_fetch_unit_fifo.sv
// Synchronous {instr, pc} buffer with flush; flush wins over push and pop.
module fetch_fifo
  import fetch_defs::*;
#(
  parameter int W     = 64,
  parameter int DEPTH = 4,
  localparam int CW   = cnt_w(DEPTH)
) (
  input  logic          clk,
  input  logic          rst_n,
  input  logic          push,
  input  logic [W-1:0]  din,
  input  logic          pop,
  input  logic          flush,
  output logic [W-1:0]  head,
  output logic          empty,
  output logic [CW-1:0] count
);
  localparam int AW = $clog2(DEPTH);

  logic [W-1:0]  mem_q [DEPTH];
  logic [W-1:0]  mem_d [DEPTH];
  logic [AW-1:0] wr_ptr_q, wr_ptr_d, rd_ptr_q, rd_ptr_d;
  logic [CW-1:0] count_q, count_d;
  logic          do_pop;

  assign do_pop = pop & (count_q != '0);

  always_comb begin
    mem_d    = mem_q;
    wr_ptr_d = wr_ptr_q;
    rd_ptr_d = rd_ptr_q;
    count_d  = count_q;
    if (flush) begin
      wr_ptr_d = '0;
      rd_ptr_d = '0;
      count_d  = '0;
    end else begin
      if (push) begin
        mem_d[wr_ptr_q] = din;
        wr_ptr_d        = wr_ptr_q + AW'(1);
      end
      if (do_pop) rd_ptr_d = rd_ptr_q + AW'(1);
      count_d = count_q + CW'(push) - CW'(do_pop);
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      for (int i = 0; i < DEPTH; i++) mem_q[i] <= '0;
      wr_ptr_q <= '0;
      rd_ptr_q <= '0;
      count_q  <= '0;
    end else begin
      mem_q    <= mem_d;
      wr_ptr_q <= wr_ptr_d;
      rd_ptr_q <= rd_ptr_d;
      count_q  <= count_d;
    end
  end

  assign head  = mem_q[rd_ptr_q];
  assign empty = (count_q == '0);
  assign count = count_q;
endmodule

// File: rtl/pc_fetch_unit.sv
// Fetch address generator with credit-limited issue, redirect flush and in-flight drop.
// Optional FETCH_MISALIGN_CHECK_EN: flag misaligned redirect targets and halt issue.
module pc_fetch_unit
  import fetch_defs::*;
#(
  parameter int              XLEN       = 32,
  parameter logic [XLEN-1:0] RESET_VEC  = XLEN'(DEF_RESET_VEC),
  parameter int              FIFO_DEPTH = 4
) (
  input  logic               clk,
  input  logic               reset,
  input  logic               stall,
  input  logic               redirect_valid,
  input  logic [XLEN-1:0]    redirect_pc,
  output logic               imem_req_valid,
  input  logic               imem_req_ready,
  output logic [XLEN-1:0]    imem_req_addr,
  input  logic               imem_rsp_valid,
  input  logic [INSTR_W-1:0] imem_rsp_data,
  output logic               instr_valid,
  input  logic               instr_ready,
  output logic [INSTR_W-1:0] instr,
  output logic [XLEN-1:0]    instr_pc
`ifdef FETCH_MISALIGN_CHECK_EN
  ,
  output logic               misalign_err,
  output logic [XLEN-1:0]    misalign_pc
`endif
);
  localparam int CW = cnt_w(FIFO_DEPTH);
  localparam int FW = INSTR_W + XLEN;

  logic [XLEN-1:0]    pc_q, pc_d, rsp_pc_q, rsp_pc_d;
  logic [CW-1:0]      inflight_q, inflight_d, drop_q, drop_d;
  logic [INSTR_W-1:0] hold_instr_q, hold_instr_d;
  logic [XLEN-1:0]    hold_pc_q, hold_pc_d;
  logic [FW-1:0]      fifo_head;
  logic               fifo_empty;
  logic [CW-1:0]      fifo_count;
  logic [CW:0]        used;
  logic               hs, push, halt;
  logic [XLEN-1:0]    target;

`ifdef FETCH_MISALIGN_CHECK_EN
  logic            merr_q, merr_d;
  logic [XLEN-1:0] mpc_q, mpc_d;
  assign target       = redirect_pc;
  assign halt         = merr_q;
  assign misalign_err = merr_q;
  assign misalign_pc  = mpc_q;
`else
  assign target = {redirect_pc[XLEN-1:2], 2'b00};
  assign halt   = 1'b0;
`endif

  // Buffered plus outstanding entries never exceed the FIFO, so a response always has room.
  assign used           = {1'b0, fifo_count} + {1'b0, inflight_q};
  assign imem_req_valid = reset & ~stall & ~redirect_valid & ~halt & (used < (CW+1)'(FIFO_DEPTH));
  assign imem_req_addr  = pc_q;
  assign hs             = imem_req_valid & imem_req_ready;
  assign push           = imem_rsp_valid & ~redirect_valid & (drop_q == '0);

  always_comb begin
    pc_d         = pc_q;
    rsp_pc_d     = rsp_pc_q;
    inflight_d   = inflight_q + CW'(hs) - CW'(imem_rsp_valid);
    drop_d       = drop_q;
    hold_instr_d = hold_instr_q;
    hold_pc_d    = hold_pc_q;
    if (!fifo_empty) begin
      hold_instr_d = fifo_head[FW-1 -: INSTR_W];
      hold_pc_d    = fifo_head[XLEN-1:0];
    end
    if (redirect_valid) begin
      pc_d     = target;
      rsp_pc_d = target;
      drop_d   = inflight_q - CW'(imem_rsp_valid);
    end else begin
      if (hs) pc_d = pc_q + XLEN'(PC_STEP);
      if (imem_rsp_valid) begin
        if (drop_q != '0) drop_d = drop_q - CW'(1);
        else              rsp_pc_d = rsp_pc_q + XLEN'(PC_STEP);
      end
    end
  end

`ifdef FETCH_MISALIGN_CHECK_EN
  always_comb begin
    merr_d = merr_q;
    mpc_d  = mpc_q;
    if (redirect_valid) begin
      merr_d = (redirect_pc[1:0] != 2'b00);
      if (redirect_pc[1:0] != 2'b00) mpc_d = redirect_pc;
    end
  end

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      merr_q <= 1'b0;
      mpc_q  <= '0;
    end else begin
      merr_q <= merr_d;
      mpc_q  <= mpc_d;
    end
  end
`endif

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      pc_q         <= RESET_VEC;
      rsp_pc_q     <= RESET_VEC;
      inflight_q   <= '0;
      drop_q       <= '0;
      hold_instr_q <= '0;
      hold_pc_q    <= '0;
    end else begin
      pc_q         <= pc_d;
      rsp_pc_q     <= rsp_pc_d;
      inflight_q   <= inflight_d;
      drop_q       <= drop_d;
      hold_instr_q <= hold_instr_d;
      hold_pc_q    <= hold_pc_d;
    end
  end

  fetch_fifo #(.W(FW), .DEPTH(FIFO_DEPTH)) u_fifo (
    .clk   (clk),
    .rst_n (reset),
    .push  (push),
    .din   ({imem_rsp_data, rsp_pc_q}),
    .pop   (instr_ready),
    .flush (redirect_valid),
    .head  (fifo_head),
    .empty (fifo_empty),
    .count (fifo_count)
  );

  assign instr_valid = ~fifo_empty;
  assign instr       = fifo_empty ? hold_instr_q : fifo_head[FW-1 -: INSTR_W];
  assign instr_pc    = fifo_empty ? hold_pc_q    : fifo_head[XLEN-1:0];
endmodule

// File: tb/tb_pc_fetch_unit.sv
// Randomized and directed bench for pc_fetch_unit against an epoch-based fetch model.
module tb_pc_fetch_unit;
  localparam int DEPTH = 4;

  // Clock / reset
  logic clk = 1'b0;
  logic rst_n = 1'b0;
  always #5 clk = ~clk;

  logic        stall, redirect_valid, imem_req_valid, imem_req_ready;
  logic [31:0] redirect_pc, imem_req_addr, imem_rsp_data, instr, instr_pc;
  logic        imem_rsp_valid, instr_valid, instr_ready;
`ifdef FETCH_MISALIGN_CHECK_EN
  logic        misalign_err;
  logic [31:0] misalign_pc;
`endif

  pc_fetch_unit #(.XLEN(32), .RESET_VEC(32'h0), .FIFO_DEPTH(DEPTH)) dut (
    .clk            (clk),
    .reset          (rst_n),
    .stall          (stall),
    .redirect_valid (redirect_valid),
    .redirect_pc    (redirect_pc),
    .imem_req_valid (imem_req_valid),
    .imem_req_ready (imem_req_ready),
    .imem_req_addr  (imem_req_addr),
    .imem_rsp_valid (imem_rsp_valid),
    .imem_rsp_data  (imem_rsp_data),
    .instr_valid    (instr_valid),
    .instr_ready    (instr_ready),
    .instr          (instr),
    .instr_pc       (instr_pc)
`ifdef FETCH_MISALIGN_CHECK_EN
    ,
    .misalign_err   (misalign_err),
    .misalign_pc    (misalign_pc)
`endif
  );

  int n_tests = 0;
  int n_fail  = 0;
  int cyc     = 0;
  int lat     = 1;
  bit chk_en  = 1'b0;
  int first_hs_cyc, first_iv_cyc, release_cyc;

  // Memory model: in-order responses, fixed latency per phase
  logic [31:0] mem_addr_q[$];
  int          mem_due_q[$];

  // Fetch model: expected buffer contents plus outstanding requests tagged by epoch
  logic [31:0] exp_q[$];
  logic [31:0] exp_pc_q[$];
  logic [31:0] infl_addr_q[$];
  int          infl_ep_q[$];
  int          epoch;
  logic [31:0] m_pc, hold_instr, hold_pc, m_mpc, ra;
  bit          m_merr, exp_rv, keep;
  int          re;

  logic [31:0] hs_log[$];
  logic [31:0] pop_log[$];
  logic [31:0] pop_data_log[$];

  function automatic logic [31:0] mem_word(input logic [31:0] a);
    return (a * 32'h9E37_79B1) ^ 32'h5A5A_0F0F;
  endfunction

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_tests++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %h expected %h (cycle %0d)", name, act, exp, cyc);
    end
  endtask

  // Memory response driver
  always @(posedge clk) begin
    cyc = cyc + 1;
    #1;
    if (rst_n && mem_due_q.size() != 0 && mem_due_q[0] <= cyc) begin
      imem_rsp_valid = 1'b1;
      imem_rsp_data  = mem_word(mem_addr_q[0]);
      void'(mem_addr_q.pop_front());
      void'(mem_due_q.pop_front());
    end else begin
      imem_rsp_valid = 1'b0;
      imem_rsp_data  = $urandom;
    end
  end

  // Scoreboard: compare every cycle, then advance the model by what the next edge does
  always @(negedge clk) begin
    if (rst_n && chk_en) begin
      exp_rv = !stall && !redirect_valid && !m_merr &&
               (exp_q.size() + infl_ep_q.size() < DEPTH);
      check("imem_req_valid", 32'(imem_req_valid), 32'(exp_rv));
      check("imem_req_addr", imem_req_addr, m_pc);
      check("instr_valid", 32'(instr_valid), 32'(exp_q.size() != 0));
      if (exp_q.size() != 0) begin
        check("instr", instr, exp_q[0]);
        check("instr_pc", instr_pc, exp_pc_q[0]);
        hold_instr = exp_q[0];
        hold_pc    = exp_pc_q[0];
      end else begin
        check("instr_hold", instr, hold_instr);
        check("instr_pc_hold", instr_pc, hold_pc);
      end
`ifdef FETCH_MISALIGN_CHECK_EN
      check("misalign_err", 32'(misalign_err), 32'(m_merr));
      check("misalign_pc", misalign_pc, m_mpc);
`endif
      if (imem_req_valid && imem_req_ready) begin
        hs_log.push_back(imem_req_addr);
        if (first_hs_cyc < 0) first_hs_cyc = cyc;
        mem_addr_q.push_back(imem_req_addr);
        mem_due_q.push_back(cyc + lat);
      end
      if (instr_valid && first_iv_cyc < 0) first_iv_cyc = cyc;
      if (instr_valid && instr_ready && !redirect_valid) begin
        pop_log.push_back(instr_pc);
        pop_data_log.push_back(instr);
      end

      keep = 1'b0;
      if (imem_rsp_valid && infl_ep_q.size() != 0) begin
        ra   = infl_addr_q.pop_front();
        re   = infl_ep_q.pop_front();
        keep = (re == epoch) && !redirect_valid;
      end
      if (redirect_valid) begin
        exp_q.delete();
        exp_pc_q.delete();
        epoch++;
`ifdef FETCH_MISALIGN_CHECK_EN
        m_pc   = redirect_pc;
        m_merr = (redirect_pc[1:0] != 2'b00);
        if (m_merr) m_mpc = redirect_pc;
`else
        m_pc = redirect_pc & 32'hFFFF_FFFC;
`endif
      end else begin
        if (exp_q.size() != 0 && instr_ready) begin
          void'(exp_q.pop_front());
          void'(exp_pc_q.pop_front());
        end
        if (keep) begin
          exp_q.push_back(mem_word(ra));
          exp_pc_q.push_back(ra);
        end
        if (exp_rv && imem_req_ready) begin
          infl_addr_q.push_back(m_pc);
          infl_ep_q.push_back(epoch);
          m_pc = m_pc + 32'd4;
        end
      end
    end
  end

  // Driver tasks
  task automatic step(input int n);
    repeat (n) @(posedge clk);
    #2;
  endtask

  task automatic do_reset(input bit s, input bit ir);
    #1;
    rst_n = 1'b0;
    chk_en = 1'b0;
    stall = s;
    instr_ready = ir;
    redirect_valid = 1'b0;
    imem_req_ready = 1'b1;
    mem_addr_q.delete(); mem_due_q.delete();
    exp_q.delete(); exp_pc_q.delete();
    infl_addr_q.delete(); infl_ep_q.delete();
    hs_log.delete(); pop_log.delete(); pop_data_log.delete();
    m_pc = 32'h0; hold_instr = 32'h0; hold_pc = 32'h0;
    epoch = 0; m_merr = 1'b0; m_mpc = 32'h0;
    first_hs_cyc = -1; first_iv_cyc = -1;
    #1;
    check("rst_req_valid", 32'(imem_req_valid), 32'h0);
    check("rst_instr_valid", 32'(instr_valid), 32'h0);
    check("rst_instr", instr, 32'h0);
    check("rst_instr_pc", instr_pc, 32'h0);
    step(2);
    rst_n = 1'b1;
    chk_en = 1'b1;
    release_cyc = cyc;
  endtask

  task automatic rand_cycle();
    stall          = ($urandom_range(0, 3) == 0);
    imem_req_ready = ($urandom_range(0, 3) != 0);
    instr_ready    = ($urandom_range(0, 2) != 0);
    redirect_valid = ($urandom_range(0, 15) == 0);
    if ($urandom_range(0, 7) == 0) redirect_pc = 32'hFFFF_FFF0 | 32'($urandom_range(0, 15));
    else                           redirect_pc = 32'($urandom_range(0, 16'hFFFF));
    step(1);
  endtask

  initial begin
    stall = 1'b0; redirect_valid = 1'b0; redirect_pc = 32'h0;
    imem_req_ready = 1'b1; instr_ready = 1'b1;
    imem_rsp_valid = 1'b0; imem_rsp_data = 32'h0;
    step(1);

    // Streaming fetch with 1-cycle memory
    do_reset(1'b0, 1'b1);
    lat = 1;
    step(12);
    check("first_req_cycle", 32'(first_hs_cyc - release_cyc), 32'd0);
    check("req_addr0", hs_log[0], 32'h0);
    check("req_addr1", hs_log[1], 32'h4);
    check("req_addr2", hs_log[2], 32'h8);
    check("out_pc0", pop_log[0], 32'h0);
    check("out_pc1", pop_log[1], 32'h4);
    check("out_pc2", pop_log[2], 32'h8);
    check("out_data0", pop_data_log[0], 32'h5A5A_0F0F);
    check("out_data1", pop_data_log[1], 32'h2287_E9CB);
    check("first_valid_latency", 32'(first_iv_cyc - first_hs_cyc), 32'd2);

    // Decode blocked: credits run out after FIFO_DEPTH requests
    do_reset(1'b0, 1'b0);
    step(12);
    check("blocked_req_count", 32'(hs_log.size()), 32'd4);
    check("blocked_last_addr", hs_log[3], 32'hC);
    check("blocked_req_valid", 32'(imem_req_valid), 32'h0);
    hs_log.delete();
    instr_ready = 1'b1;
    step(6);
    check("resume_addr", hs_log[0], 32'h10);

    // Redirect with two stale requests outstanding on a 3-cycle memory
    do_reset(1'b1, 1'b1);
    lat = 3;
    step(2);
    stall = 1'b0;
    step(2);
    stall = 1'b1;
    check("inflight_reqs", 32'(hs_log.size()), 32'd2);
    hs_log.delete(); pop_log.delete();
    stall = 1'b0;
    redirect_valid = 1'b1;
    redirect_pc = 32'h100;
    step(1);
    redirect_valid = 1'b0;
    step(15);
    check("redir_first_req", hs_log[0], 32'h100);
    check("redir_first_out", pop_log[0], 32'h100);

    // Redirect coinciding with a response and a pop
    do_reset(1'b0, 1'b1);
    lat = 1;
    step(10);
    redirect_valid = 1'b1;
    redirect_pc = 32'h40;
    step(1);
    redirect_valid = 1'b0;
    @(negedge clk);
    check("redir_fifo_empty", 32'(instr_valid), 32'h0);
    check("redir_pc", imem_req_addr, 32'h40);
    step(6);

    // Stall with full buffer: drains, no issue, pc held
    do_reset(1'b0, 1'b0);
    step(10);
    stall = 1'b1;
    instr_ready = 1'b1;
    hs_log.delete();
    step(5);
    check("stall_no_req", 32'(hs_log.size()), 32'd0);
    check("stall_pc_held", imem_req_addr, 32'h10);
    check("stall_drained", 32'(instr_valid), 32'h0);
    stall = 1'b0;
    step(3);
    check("stall_resume", hs_log[0], 32'h10);

`ifdef FETCH_MISALIGN_CHECK_EN
    // Misaligned redirect halts issue until an aligned redirect
    do_reset(1'b0, 1'b1);
    step(5);
    redirect_valid = 1'b1;
    redirect_pc = 32'h102;
    step(1);
    redirect_valid = 1'b0;
    hs_log.delete();
    @(negedge clk);
    check("mis_err_set", 32'(misalign_err), 32'h1);
    check("mis_pc", misalign_pc, 32'h102);
    check("mis_no_req", 32'(imem_req_valid), 32'h0);
    step(5);
    check("mis_halted", 32'(hs_log.size()), 32'd0);
    redirect_valid = 1'b1;
    redirect_pc = 32'h200;
    step(1);
    redirect_valid = 1'b0;
    step(6);
    check("mis_err_clear", 32'(misalign_err), 32'h0);
    check("mis_resume", hs_log[0], 32'h200);
`endif

    // Randomized traffic, including a reset in the middle of activity
    for (int chunk = 0; chunk < 4; chunk++) begin
      do_reset(1'($urandom_range(0, 1)), 1'($urandom_range(0, 1)));
      lat = $urandom_range(1, 3);
      repeat (400) rand_cycle();
      redirect_valid = 1'b0;
    end
    step(4);

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end
endmodule
